// File: rtl/mma_sequencer_if.sv
// Command, feed-read and drain-write signals between the host, the sequencer and
// the array feeders. The slave modport is the sequencer side.
interface mma_sequencer_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_drain_i;
    logic [ADDR_WIDTH-1:0] cmd_a_addr_i;
    logic [ADDR_WIDTH-1:0] cmd_b_addr_i;
    logic [ADDR_WIDTH-1:0] cmd_c_addr_i;
    logic                  abort_i;
    logic                  rd_ready_i;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_a_addr_o;
    logic [ADDR_WIDTH-1:0] rd_b_addr_o;
    logic                  feed_last_o;
    logic                  wr_ready_i;
    logic                  drain_en_o;
    logic [ADDR_WIDTH-1:0] wr_c_addr_o;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  cmd_valid_i, cmd_drain_i, cmd_a_addr_i, cmd_b_addr_i, cmd_c_addr_i,
        input  abort_i, rd_ready_i, wr_ready_i,
        output cmd_ready_o, rd_en_o, rd_a_addr_o, rd_b_addr_o, feed_last_o,
        output drain_en_o, wr_c_addr_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_drain_i, cmd_a_addr_i, cmd_b_addr_i, cmd_c_addr_i,
        output abort_i, rd_ready_i, wr_ready_i,
        input  cmd_ready_o, rd_en_o, rd_a_addr_o, rd_b_addr_o, feed_last_o,
        input  drain_en_o, wr_c_addr_o, busy_o, done_o
    );
endinterface

// File: rtl/mma_sequencer.sv
// Command sequencer for the systolic MMA array: feeds T_C A/B rows, waits T_D
// flush cycles, optionally drains T_C result rows to C, then pulses done.
module mma_sequencer #(
    parameter int SYS_ARRAY_SIZE = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int T_C            = SYS_ARRAY_SIZE,
    parameter int T_D            = 2 * SYS_ARRAY_SIZE
) (
    input logic           clk_i,
    input logic           rst_ni,
    mma_sequencer_if.slave bus
);
    localparam int ROW_W = (T_C > 1) ? $clog2(T_C) : 1;
    localparam int CYC_W = (T_D > 0) ? $clog2(T_D + 1) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(T_C - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_D - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [ROW_W-1:0]      row_reg, row_next;
    logic [CYC_W-1:0]      cyc_reg, cyc_next;
    logic [ADDR_WIDTH-1:0] a_base_reg, b_base_reg, c_base_reg;
    logic                  drain_reg;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] row_ext;

    assign accept  = (state_reg == IDLE) && bus.cmd_valid_i;
    assign row_ext = ADDR_WIDTH'(row_reg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            cyc_reg   <= cyc_next;
        end
    end

    // Command fields are captured only on accept and held for the whole command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_base_reg <= '0;
            b_base_reg <= '0;
            c_base_reg <= '0;
            drain_reg  <= 1'b0;
        end else if (accept) begin
            a_base_reg <= bus.cmd_a_addr_i;
            b_base_reg <= bus.cmd_b_addr_i;
            c_base_reg <= bus.cmd_c_addr_i;
            drain_reg  <= bus.cmd_drain_i;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        cyc_next   = cyc_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_next = FEED;
                    row_next   = '0;
                    cyc_next   = '0;
                end
            end
            FEED: begin
                if (bus.rd_ready_i) begin
                    if (row_reg == ROW_LAST) begin
                        state_next = COMPUTE;
                        row_next   = '0;
                    end else begin
                        row_next = row_reg + ROW_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next   = '0;
                    state_next = drain_reg ? DRAIN : DONE;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            DRAIN: begin
                if (bus.wr_ready_i) begin
                    if (row_reg == ROW_LAST) begin
                        state_next = DONE;
                        row_next   = '0;
                    end else begin
                        row_next = row_reg + ROW_W'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort overrides everything except in IDLE, where a new command may be taken.
        if (bus.abort_i && (state_reg != IDLE)) begin
            state_next = IDLE;
            row_next   = '0;
            cyc_next   = '0;
        end
    end

    always_comb begin
        bus.cmd_ready_o = (state_reg == IDLE);
        bus.busy_o      = (state_reg != IDLE);
        bus.rd_en_o     = (state_reg == FEED);
        bus.rd_a_addr_o = '0;
        bus.rd_b_addr_o = '0;
        bus.feed_last_o = (state_reg == FEED) && (row_reg == ROW_LAST);
        bus.drain_en_o  = (state_reg == DRAIN);
        bus.wr_c_addr_o = '0;
        bus.done_o      = (state_reg == DONE);
        if (state_reg == FEED) begin
            bus.rd_a_addr_o = a_base_reg + row_ext;
            bus.rd_b_addr_o = b_base_reg + row_ext;
        end
        if (state_reg == DRAIN) begin
            bus.wr_c_addr_o = c_base_reg + row_ext;
        end
    end
endmodule

// File: tb/tb_mma_sequencer.sv
// Directed bench for mma_sequencer: expected feed/drain/done events are queued at
// command issue and matched, cycle-stamped, against what the sequencer produces.
module tb_mma_sequencer;
    localparam int AW = 64;
    localparam int TC = 2;
    localparam int TD = 4;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          last;
        logic [31:0]   cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mma_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    mma_sequencer #(.SYS_ARRAY_SIZE(2), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Monitor: one transaction per cycle at most, sampled mid-low-phase.
    always @(negedge clk) begin : monitor
        ev_t o;
        ev_t e;
        logic hit;
        #2;
        hit = 1'b0;
        o = '0;
        if (rst_n) begin
            if (bus.rd_en_o && bus.rd_ready_i) begin
                o = '{kind: 2'd1, a: bus.rd_a_addr_o, b: bus.rd_b_addr_o,
                      last: bus.feed_last_o, cyc: 32'(cyc)};
                hit = 1'b1;
            end else if (bus.drain_en_o && bus.wr_ready_i) begin
                o = '{kind: 2'd2, a: bus.wr_c_addr_o, b: '0, last: 1'b0, cyc: 32'(cyc)};
                hit = 1'b1;
            end else if (bus.done_o) begin
                o = '{kind: 2'd3, a: '0, b: '0, last: 1'b0, cyc: 32'(cyc)};
                hit = 1'b1;
            end
            if (hit) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 192'(o), 192'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 192'(o), 192'(e));
                    $display("txn kind=%0d a=%h b=%h last=%0b cyc=%0d", o.kind, o.a, o.b, o.last, o.cyc);
                end
            end
        end
    end

    // Drive one command at the next edge and queue the first nev expected events (all if nev<0).
    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                         input bit drn, input int rs, input int ws, input bit ab,
                         input int nev, output int e);
        ev_t list[$];
        int  base;
        @(negedge clk);
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_drain_i  = drn;
        bus.cmd_a_addr_i = a;
        bus.cmd_b_addr_i = b;
        bus.cmd_c_addr_i = c;
        bus.abort_i      = ab;
        e = cyc + 1;
        for (int r = 0; r < TC; r++)
            list.push_back('{kind: 2'd1, a: a + AW'(r), b: b + AW'(r),
                             last: (r == TC - 1), cyc: 32'(e + rs + r)});
        base = e + rs + TC + TD;
        if (drn) begin
            for (int r = 0; r < TC; r++)
                list.push_back('{kind: 2'd2, a: c + AW'(r), b: '0, last: 1'b0, cyc: 32'(base + ws + r)});
            base = base + ws + TC;
        end
        list.push_back('{kind: 2'd3, a: '0, b: '0, last: 1'b0, cyc: 32'(base)});
        for (int i = 0; i < list.size(); i++)
            if (nev < 0 || i < nev) exp_q.push_back(list[i]);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.abort_i     = 1'b0;
        if (rs > 0) bus.rd_ready_i = 1'b0;
        #3 chk("busy_after_accept", {bus.cmd_ready_o, bus.busy_o}, 2'b01);
    endtask

    task automatic run(input int e, input int rs, input int ws, input bit drn);
        for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (cyc == e + rs) bus.rd_ready_i = 1'b1;
            if (drn && ws > 0 && cyc == e + rs + TC + TD) bus.wr_ready_i = 1'b0;
            if (cyc == e + rs + TC + TD + ws) bus.wr_ready_i = 1'b1;
        end
        chk("queue_drained", 192'(exp_q.size()), 192'(0));
        exp_q.delete();
        bus.rd_ready_i = 1'b1;
        bus.wr_ready_i = 1'b1;
        @(negedge clk);
        #3 chk("idle_after", {bus.cmd_ready_o, bus.busy_o, bus.done_o}, 3'b100);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {bus.cmd_ready_o, bus.busy_o, bus.rd_en_o, bus.feed_last_o,
                  bus.drain_en_o, bus.done_o}, 6'b100000);
        chk({tag, "_addr"}, {bus.rd_a_addr_o, bus.rd_b_addr_o, bus.wr_c_addr_o}, 192'(0));
    endtask

    initial begin : stim
        int e;
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_drain_i  = 1'b0;
        bus.cmd_a_addr_i = '0;
        bus.cmd_b_addr_i = '0;
        bus.cmd_c_addr_i = '0;
        bus.abort_i      = 1'b0;
        bus.rd_ready_i   = 1'b1;
        bus.wr_ready_i   = 1'b1;
        repeat (2) @(negedge clk);
        #3 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic drain command, then the same without drain.
        issue(64'h100, 64'h200, 64'h300, 1'b1, 0, 0, 1'b0, -1, e);
        run(e, 0, 0, 1'b1);
        issue(64'h100, 64'h200, 64'h300, 1'b0, 0, 0, 1'b0, -1, e);
        run(e, 0, 0, 1'b0);

        // Feed stall of three cycles; then a drain stall with abort raised alongside accept.
        issue(64'h100, 64'h200, 64'h300, 1'b1, 3, 0, 1'b0, -1, e);
        run(e, 3, 0, 1'b1);
        issue(64'h40, 64'h50, 64'h60, 1'b1, 0, 2, 1'b1, -1, e);
        run(e, 0, 2, 1'b1);

        // Address wrap past all-ones on both feed and drain.
        issue({AW{1'b1}}, 64'h10, {AW{1'b1}}, 1'b1, 0, 0, 1'b0, -1, e);
        run(e, 0, 0, 1'b1);

        // Abort in cycle 5 (COMPUTE): feed rows only, no drain or done.
        issue(64'h100, 64'h200, 64'h300, 1'b1, 0, 0, 1'b0, TC, e);
        repeat (4) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        #3 chk("abort_idle", {bus.cmd_ready_o, bus.busy_o}, 2'b10);
        repeat (8) @(negedge clk);
        chk("abort_no_more", 192'(exp_q.size()), 192'(0));
        issue(64'h100, 64'h200, 64'h300, 1'b1, 0, 0, 1'b0, -1, e);
        run(e, 0, 0, 1'b1);

        // Reset during the first drain cycle.
        issue(64'h100, 64'h200, 64'h300, 1'b1, 0, 0, 1'b0, TC + 1, e);
        repeat (6) @(negedge clk);
        #4 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_mid_drain");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_no_more", 192'(exp_q.size()), 192'(0));
        issue(64'h100, 64'h200, 64'h300, 1'b1, 0, 0, 1'b0, -1, e);
        run(e, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
